// File: rtl/gray_counter_pkg.sv
// Shared operation select for the Gray counter.
// Maps clr/load/en onto one priority-resolved operation.
package gray_counter_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_CLR  = 2'd1,
    OP_LOAD = 2'd2,
    OP_STEP = 2'd3
  } op_e;

  // clr beats load beats en
  function automatic op_e op_sel(input logic clr, input logic load, input logic en);
    op_e op;
    op = OP_HOLD;
    if (clr)       op = OP_CLR;
    else if (load) op = OP_LOAD;
    else if (en)   op = OP_STEP;
    return op;
  endfunction

endpackage

// File: rtl/gray_counter_bin2gray.sv
// Binary to Gray conversion; purely combinational, zero latency, no flow control.
// Inverse pair of the downstream gray2bin decoder.
module gray_counter_bin2gray #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter.sv
// Registered up/down Gray counter with binary view and wrap pulse.
// One cycle latency from inputs to flopped outputs; always accepts, no backpressure.
module gray_counter
  import gray_counter_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter logic [WIDTH-1:0] INIT_BIN = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] gray_q,
  output logic [WIDTH-1:0] bin_q,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);

  op_e              op;
  logic [WIDTH-1:0] next_bin;
  logic [WIDTH-1:0] next_gray;
  logic             next_wrap;

  always_comb begin
    op        = op_sel(clr, load, en);
    next_bin  = bin_q;
    next_wrap = 1'b0;
    unique case (op)
      OP_CLR:  next_bin = '0;
      OP_LOAD: next_bin = load_bin;
      OP_STEP: begin
        // wrap flags the step that crosses the modulus boundary
        if (up) begin
          next_bin  = bin_q + WIDTH'(1);
          next_wrap = &bin_q;
        end else begin
          next_bin  = bin_q - WIDTH'(1);
          next_wrap = ~|bin_q;
        end
      end
      default: next_bin = bin_q;
    endcase
  end

  // Gray is derived from next_bin so both registers stay coherent.
  gray_counter_bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
    .bin  (next_bin),
    .gray (next_gray)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= INIT_BIN;
      gray_q <= INIT_GRAY;
      wrap   <= 1'b0;
    end else begin
      bin_q  <= next_bin;
      gray_q <= next_gray;
      wrap   <= next_wrap;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Directed and randomized checks of gray_counter (WIDTH=4) against an arithmetic reference model.
module tb_gray_counter;

  localparam int W = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_bin = '0;
  logic         en = 1'b0;
  logic         up = 1'b1;

  logic [W-1:0] gray0, bin0, gray3, bin3;
  logic         wrap0, wrap3;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(W), .INIT_BIN(4'd0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_bin(load_bin),
    .en(en), .up(up), .gray_q(gray0), .bin_q(bin0), .wrap(wrap0)
  );

  gray_counter #(.WIDTH(W), .INIT_BIN(4'd3)) dut3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_bin(load_bin),
    .en(en), .up(up), .gray_q(gray3), .bin_q(bin3), .wrap(wrap3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Gray image of an integer count, from the definition b xor (b/2).
  function automatic int gray_of(input int b);
    return (b ^ (b / 2)) % MOD;
  endfunction

  // Decode Gray by prefix-xor over all right shifts.
  function automatic int gray_decode(input int g);
    int b;
    b = 0;
    for (int k = 0; k < W; k++) b = b ^ (g >> k);
    return b % MOD;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model state for both instances.
  int m_bin [2];
  int m_wrap [2];

  task automatic model_step(input int idx);
    m_wrap[idx] = 0;
    if (clr) m_bin[idx] = 0;
    else if (load) m_bin[idx] = int'(load_bin);
    else if (en) begin
      if (up) begin
        m_wrap[idx] = (m_bin[idx] == MOD - 1) ? 1 : 0;
        m_bin[idx]  = (m_bin[idx] + 1) % MOD;
      end else begin
        m_wrap[idx] = (m_bin[idx] == 0) ? 1 : 0;
        m_bin[idx]  = (m_bin[idx] + MOD - 1) % MOD;
      end
    end
  endtask

  initial begin
    logic [W-1:0] up_seq [16];
    logic [W-1:0] prev0, prev3;
    logic         en_only;
    up_seq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
               4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    // Reset state
    #12;
    check("rst_bin0",  32'(bin0),  32'h0);
    check("rst_gray0", 32'(gray0), 32'h0);
    check("rst_wrap0", 32'(wrap0), 32'h0);
    check("rst_bin3",  32'(bin3),  32'h3);
    check("rst_gray3", 32'(gray3), 32'h2);
    check("rst_wrap3", 32'(wrap3), 32'h0);
    rst_n = 1'b1;

    // 1. Full up-count cycle
    en = 1'b1; up = 1'b1;
    prev0 = gray0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("up_gray[%0d]", i), 32'(gray0), 32'(up_seq[i]));
      check($sformatf("up_bin[%0d]", i),  32'(bin0),  32'((i + 1) % 16));
      check($sformatf("up_wrap[%0d]", i), 32'(wrap0), (i == 15) ? 32'd1 : 32'd0);
      check($sformatf("up_1bit[%0d]", i), 32'($countones(prev0 ^ gray0)), 32'd1);
      prev0 = gray0;
    end

    // 2. Down step through zero
    up = 1'b0;
    tick();
    check("dn_bin_f",  32'(bin0),  32'hF);
    check("dn_gray_8", 32'(gray0), 32'h8);
    check("dn_wrap_1", 32'(wrap0), 32'h1);
    tick();
    check("dn_bin_e",  32'(bin0),  32'hE);
    check("dn_gray_9", 32'(gray0), 32'h9);
    check("dn_wrap_0", 32'(wrap0), 32'h0);

    // 3. Load beats enable
    load = 1'b1; load_bin = 4'hA; en = 1'b1; up = 1'b1;
    tick();
    check("ld_bin",  32'(bin0),  32'hA);
    check("ld_gray", 32'(gray0), 32'hF);
    check("ld_wrap", 32'(wrap0), 32'h0);

    // 4. Clear beats load and enable
    load_bin = 4'h7;
    tick();
    check("pre_clr_bin", 32'(bin0), 32'h7);
    clr = 1'b1; load_bin = 4'hC;
    tick();
    check("clr_bin",  32'(bin0),  32'h0);
    check("clr_gray", 32'(gray0), 32'h0);
    check("clr_wrap", 32'(wrap0), 32'h0);
    clr = 1'b0;

    // 5. Asynchronous reset mid-count
    load_bin = 4'h5;
    tick();
    load = 1'b0;
    check("pre_rst_bin", 32'(bin0), 32'h5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_bin",  32'(bin0),  32'h0);
    check("arst_gray", 32'(gray0), 32'h0);
    check("arst_wrap", 32'(wrap0), 32'h0);
    tick();
    check("arst_hold_bin", 32'(bin0), 32'h0);
    rst_n = 1'b1;
    tick();
    check("resume_bin",  32'(bin0),  32'h1);
    check("resume_gray", 32'(gray0), 32'h1);

    // 6. Randomized run from a fresh reset, both instances modelled
    rst_n = 1'b0; en = 1'b0; load = 1'b0; clr = 1'b0;
    #3;
    check("rr_bin3", 32'(bin3), 32'h3);
    rst_n = 1'b1;
    m_bin[0] = 0; m_bin[1] = 3; m_wrap[0] = 0; m_wrap[1] = 0;
    for (int c = 0; c < 10000; c++) begin
      en       = ($urandom_range(0, 7) != 0);
      up       = $urandom_range(0, 1) == 1;
      load     = ($urandom_range(0, 15) == 0);
      clr      = ($urandom_range(0, 40) == 0);
      load_bin = W'($urandom_range(0, MOD - 1));
      en_only  = en && !load && !clr;
      prev0 = gray0; prev3 = gray3;
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check("r_bin0",  32'(bin0),  32'(m_bin[0]));
      check("r_gray0", 32'(gray0), 32'(gray_of(m_bin[0])));
      check("r_wrap0", 32'(wrap0), 32'(m_wrap[0]));
      check("r_bin3",  32'(bin3),  32'(m_bin[1]));
      check("r_gray3", 32'(gray3), 32'(gray_of(m_bin[1])));
      check("r_wrap3", 32'(wrap3), 32'(m_wrap[1]));
      check("r_dec3",  32'(gray_decode(int'(gray3))), 32'(m_bin[1]));
      if (en_only) begin
        check("r_1bit0", 32'($countones(prev0 ^ gray0)), 32'd1);
        check("r_1bit3", 32'($countones(prev3 ^ gray3)), 32'd1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
